// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: splits and classifies the incoming word, extends the
// immediate, forms the jump address, and buffers decoded entries in a small output FIFO.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instruction,
    input  logic [XLEN-1:0]  PC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       OpCode,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [XLEN-1:0]  ImmExt,
    output logic [25:0]      target,
    output logic [XLEN-1:0]  JumpAddr,
    output logic [1:0]       InstType
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] TYPE_R = 2'd0;
    localparam logic [1:0] TYPE_I = 2'd1;
    localparam logic [1:0] TYPE_J = 2'd2;

    typedef struct packed {
        logic [5:0]      opCode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] immExt;
        logic [25:0]     target;
        logic [XLEN-1:0] jumpAddr;
        logic [1:0]      instType;
    } entry_t;

    function automatic entry_t decodeWord(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        entry_t                 e;
        logic signed [XLEN-1:0] immSext;
        e        = '0;
        immSext  = {{(XLEN-16){instr[15]}}, instr[15:0]};
        e.opCode = instr[31:26];
        case (instr[31:26])
            6'd0: begin
                e.instType = TYPE_R;
                e.rs       = instr[25:21];
                e.rt       = instr[20:16];
                e.rd       = instr[15:11];
                e.shamt    = instr[10:6];
                e.funct    = instr[5:0];
            end
            6'd2, 6'd3, 6'd26: begin
                e.instType = TYPE_J;
                e.target   = instr[25:0];
                // Upper bits come from the address of the delay slot (PC+4).
                e.jumpAddr = ((pc + XLEN'(4)) & ~XLEN'(32'h0FFF_FFFF))
                           | XLEN'({instr[25:0], 2'b00});
            end
            default: begin
                e.instType = TYPE_I;
                e.rs       = instr[25:21];
                e.rt       = instr[20:16];
                case (instr[31:26])
                    6'd12, 6'd13, 6'd14: e.immExt = XLEN'(instr[15:0]);
                    6'd15:               e.immExt = immSext <<< 16;
                    default:             e.immExt = immSext;
                endcase
            end
        endcase
        return e;
    endfunction

    entry_t         fifoMem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    entry_t         headEntry;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Control state: reset wins over flush, flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is data only and is never reset.
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= decodeWord(Instruction, PC);
    end

    assign headEntry = out_valid ? fifoMem[rdPtr] : '0;

    assign OpCode   = headEntry.opCode;
    assign Rs       = headEntry.rs;
    assign Rt       = headEntry.rt;
    assign Rd       = headEntry.rd;
    assign shamt    = headEntry.shamt;
    assign funct    = headEntry.funct;
    assign ImmExt   = headEntry.immExt;
    assign target   = headEntry.target;
    assign JumpAddr = headEntry.jumpAddr;
    assign InstType = headEntry.instType;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: fixed vector table, directed handshake/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] tgt;
        logic [31:0] ja;
        logic [1:0]  typ;
    } dec_t;

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [31:0] pc;
        dec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN, flush, inValid, inReady, outValid, outReady;
    logic [31:0] instr, pc;
    logic [5:0]  opCode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] immExt, jumpAddr;
    logic [25:0] target;
    logic [1:0]  instType;

    int   total = 0;
    int   bad   = 0;
    dec_t q[$];
    bit   lastPush;
    vec_t tbl[12];

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rstN), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .Instruction(instr), .PC(pc),
        .out_valid(outValid), .out_ready(outReady),
        .OpCode(opCode), .Rs(rs), .Rt(rt), .Rd(rd), .shamt(shamt), .funct(funct),
        .ImmExt(immExt), .target(target), .JumpAddr(jumpAddr), .InstType(instType)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic chkBit(input string nm, input logic got, input logic exp);
        chk(nm, 128'(got), 128'(exp));
    endtask

    task automatic chkDec(input string nm, input dec_t got, input dec_t exp);
        chk(nm, {4'b0, got}, {4'b0, exp});
    endtask

    function automatic dec_t cap();
        dec_t d;
        d.opc = opCode; d.rs = rs; d.rt = rt; d.rd = rd; d.sh = shamt; d.fn = funct;
        d.imm = immExt; d.tgt = target; d.ja = jumpAddr; d.typ = instType;
        return d;
    endfunction

    function automatic dec_t mk(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] d, input logic [4:0] h, input logic [5:0] f,
                                input logic [31:0] im, input logic [25:0] tg,
                                input logic [31:0] ja, input logic [1:0] ty);
        dec_t r;
        r.opc = o; r.rs = s; r.rt = t; r.rd = d; r.sh = h; r.fn = f;
        r.imm = im; r.tgt = tg; r.ja = ja; r.typ = ty;
        return r;
    endfunction

    // Reference decode from the instruction-set rules using plain integer arithmetic.
    function automatic dec_t refDecode(input logic [31:0] w, input logic [31:0] p);
        dec_t           d;
        int             op;
        longint         simm;
        longint unsigned p4;
        d   = '0;
        op  = int'(w[31:26]);
        d.opc = w[31:26];
        if (op == 0) begin
            d.typ = 2'd0;
            d.rs = w[25:21]; d.rt = w[20:16]; d.rd = w[15:11]; d.sh = w[10:6]; d.fn = w[5:0];
        end else if (op == 2 || op == 3 || op == 26) begin
            d.typ = 2'd2;
            d.tgt = w[25:0];
            p4    = (longint'(p) + 64'd4) % 64'h1_0000_0000;
            d.ja  = 32'(p4 - (p4 % 64'h1000_0000) + longint'(w[25:0]) * 4);
        end else begin
            d.typ = 2'd1;
            d.rs = w[25:21]; d.rt = w[20:16];
            simm = longint'(w[15:0]);
            if (simm >= 32768) simm = simm - 65536;
            if (op >= 12 && op <= 14) d.imm = 32'(longint'(w[15:0]));
            else if (op == 15)        d.imm = 32'(simm * 65536);
            else                      d.imm = 32'(simm);
        end
        return d;
    endfunction

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        logic [5:0]  op;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: op = 6'd0;
            1: op = 6'd2;
            2: op = 6'd3;
            3: op = 6'd26;
            4: op = 6'd12;
            5: op = 6'd13;
            6: op = 6'd14;
            7: op = 6'd15;
            default: op = 6'($urandom_range(0, 63));
        endcase
        w[31:26] = op;
        return w;
    endfunction

    // One clock: check state against the model, record the transfers, advance to next negedge.
    task automatic step();
        bit pushW, popW;
        chkBit("out_valid_vs_model", outValid, q.size() != 0);
        chkBit("in_ready_vs_model", inReady, q.size() != DEPTH);
        if (!outValid) chkDec("idle_fields_zero", cap(), '0);
        pushW = inValid && inReady && !flush;
        popW  = outValid && outReady && !flush;
        if (popW) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_empty got=pop want=no_pop");
            end else begin
                chkDec("stream_word", cap(), q.pop_front());
            end
        end
        if (flush) q.delete();
        else if (pushW) q.push_back(refDecode(instr, pc));
        lastPush = pushW;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        chkBit("rst_out_valid", outValid, 1'b0);
        chkBit("rst_in_ready", inReady, 1'b1);
        chkDec("rst_fields", cap(), '0);
    endtask

    initial begin
        tbl[0]  = '{"add",      32'h012A4020, 32'h0040_0000, mk(6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h0, 26'h0, 32'h0, 2'd0)};
        tbl[1]  = '{"addi",     32'h2108FFFF, 32'h0040_0004, mk(6'd8, 5'd8, 5'd8, 5'd0, 5'd0, 6'h0, 32'hFFFF_FFFF, 26'h0, 32'h0, 2'd1)};
        tbl[2]  = '{"andi",     32'h3108FFFF, 32'h0040_0008, mk(6'd12, 5'd8, 5'd8, 5'd0, 5'd0, 6'h0, 32'h0000_FFFF, 26'h0, 32'h0, 2'd1)};
        tbl[3]  = '{"lui",      32'h3C081234, 32'h0040_000C, mk(6'd15, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 32'h1234_0000, 26'h0, 32'h0, 2'd1)};
        tbl[4]  = '{"jal",      32'h0C000010, 32'h8000_0FFC, mk(6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h10, 32'h8000_0040, 2'd2)};
        tbl[5]  = '{"j26_wrap", 32'h6BFFFFFF, 32'hFFFF_FFFC, mk(6'd26, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h3FF_FFFF, 32'h0FFF_FFFC, 2'd2)};
        tbl[6]  = '{"lui_neg",  32'h3C018000, 32'h0000_0000, mk(6'd15, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 32'h8000_0000, 26'h0, 32'h0, 2'd1)};
        tbl[7]  = '{"ori",      32'h34218000, 32'h0000_0010, mk(6'd13, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 32'h0000_8000, 26'h0, 32'h0, 2'd1)};
        tbl[8]  = '{"r_ones",   32'h03FFFFFF, 32'h0000_0020, mk(6'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 32'h0, 26'h0, 32'h0, 2'd0)};
        tbl[9]  = '{"j_ones",   32'h0BFFFFFF, 32'h1234_5678, mk(6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h3FF_FFFF, 32'h1FFF_FFFC, 2'd2)};
        tbl[10] = '{"slti_neg", 32'h2822FFFE, 32'h0000_0030, mk(6'd10, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 32'hFFFF_FFFE, 26'h0, 32'h0, 2'd1)};
        tbl[11] = '{"xori",     32'h38438001, 32'h0000_0040, mk(6'd14, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 32'h0000_8001, 26'h0, 32'h0, 2'd1)};

        instr = '0; pc = '0; lastPush = 1'b0;
        doReset();

        // Table vectors: push one word, check it one cycle later, then pop it.
        for (int i = 0; i < 12; i++) begin
            inValid = 1'b1; instr = tbl[i].instr; pc = tbl[i].pc; outReady = 1'b0;
            step();
            inValid = 1'b0;
            chkBit({tbl[i].nm, "_latency"}, outValid, 1'b1);
            chkDec(tbl[i].nm, cap(), tbl[i].exp);
            outReady = 1'b1;
            step();
            outReady = 1'b0;
        end

        // Backpressure with a full FIFO.
        doReset();
        inValid = 1'b1; instr = tbl[0].instr; pc = tbl[0].pc; step();
        instr = tbl[3].instr; pc = tbl[3].pc; step();
        instr = tbl[4].instr; pc = tbl[4].pc;
        chkBit("bp_full_in_ready", inReady, 1'b0);
        chkDec("bp_head_word1", cap(), tbl[0].exp);
        step();
        chkBit("bp_still_full", inReady, 1'b0);
        chkDec("bp_hold_word1", cap(), tbl[0].exp);
        outReady = 1'b1;
        step();
        chkBit("bp_ready_after_pop", inReady, 1'b1);
        chkDec("bp_head_word2", cap(), tbl[3].exp);
        step();
        chkBit("bp_third_accepted", lastPush, 1'b1);
        inValid = 1'b0;
        chkDec("bp_head_word3", cap(), tbl[4].exp);
        step();
        chkBit("bp_drained", outValid, 1'b0);

        // Flush with two buffered entries and a pending input.
        doReset();
        inValid = 1'b1; instr = tbl[1].instr; pc = tbl[1].pc; step();
        instr = tbl[2].instr; step();
        flush = 1'b1; outReady = 1'b1; instr = tbl[5].instr; pc = tbl[5].pc;
        step();
        flush = 1'b0; inValid = 1'b0;
        chkBit("flush_out_valid", outValid, 1'b0);
        chkBit("flush_in_ready", inReady, 1'b1);
        step();
        chkBit("flush_input_absent", outValid, 1'b0);

        // Flush while a push would otherwise be accepted.
        outReady = 1'b0; inValid = 1'b1; instr = tbl[6].instr; step();
        flush = 1'b1; instr = tbl[7].instr; step();
        flush = 1'b0; inValid = 1'b0;
        chkBit("flush_push_dropped", outValid, 1'b0);
        step();

        // Reset mid-stream.
        inValid = 1'b1; instr = tbl[8].instr; step();
        instr = tbl[9].instr; step();
        doReset();
        step();
        chkBit("midrst_empty", outValid, 1'b0);

        // Streaming: one word per cycle across pointer wrap.
        inValid = 1'b1; outReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            instr = randWord();
            pc    = $urandom & 32'hFFFF_FFFC;
            step();
        end
        inValid = 1'b0;
        step();
        step();

        // Random handshakes with occasional flush; producer holds a stalled word.
        for (int i = 0; i < 400; i++) begin
            if (!(inValid && !lastPush)) begin
                inValid = 1'($urandom_range(0, 1));
                instr   = randWord();
                pc      = $urandom & 32'hFFFF_FFFC;
            end
            outReady = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        chkBit("final_empty", outValid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised MIPS instruction-decode pipeline stage with valid/ready handshakes on both sides and a DEPTH-entry output FIFO. It sits between instruction fetch and register read. Beyond field splitting it classifies the instruction type, extends the immediate to XLEN bits and forms the absolute jump address. It also supports a synchronous flush for branch redirects.

## Interface
- XLEN, 32: width of PC, extended immediate and jump address (32 or 64).
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  Instruction/PC valid.
- in_ready  out  1  stage can accept; equals (count != DEPTH), no combinational path from out_ready.
- Instruction  in  32  raw instruction word.
- PC  in  XLEN  address of Instruction.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  consumer takes head.
- OpCode  out  6  Instruction[31:26].
- Rs, Rt, Rd, shamt  out  5 each  register/shift fields.
- funct  out  6  function field.
- ImmExt  out  XLEN  extended immediate.
- target  out  26  jump target field.
- JumpAddr  out  XLEN  {PCplus4[XLEN-1:28], target, 2'b00}.
- InstType  out  2  0=R, 1=I, 2=J; 3 never produced.

## Operation
- Classification: OpCode 0 → R; OpCode 2, 3, 26 → J; all others → I.
- R: Rs, Rt, Rd, shamt, funct from bits; ImmExt=0; target=0; JumpAddr=0.
- J: target=Instruction[25:0]; JumpAddr as above with PCplus4 = PC+4 (mod 2^XLEN). Rs, Rt, Rd, shamt, funct and ImmExt are 0.
- I: Rs, Rt from bits; Rd=shamt=funct=0; target=0; JumpAddr=0. ImmExt per OpCode:
  - 12, 13, 14 (andi/ori/xori): zero-extend.
  - 15 (lui): {sign-extend of imm, 16'b0} truncated/extended to XLEN.
  - All others: sign-extend imm[15].
- Decode is computed on the input word and written into the FIFO on push; all outputs come from the head entry.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- Push and pop in the same cycle: count unchanged, pointers both advance, including when count==DEPTH-1 or count==1.
- When out_valid=0, all field outputs are driven 0, not stale data.
- Flush: next cycle count=0 and pointers=0. A same-cycle push is dropped and a same-cycle pop does not count as consumed.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset: on a clk edge with rst_n=0, count=0 and pointers=0. The following cycle shows out_valid=0, in_ready=1 and all field outputs 0. FIFO storage is not reset.
- Reset has priority over flush, and flush has priority over push/pop.
- Reset mid-stream discards all entries; there is no partial output.
- Latency: a push at edge N presents the entry with out_valid=1 after edge N when the FIFO was empty (1 cycle).
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Full (count==DEPTH): in_ready=0 even if out_ready=1 in that cycle. in_ready rises the cycle after a pop.
- Outputs are held stable while out_valid=1 and out_ready=0.
- Input handshake rule: producer holds Instruction/PC while in_valid=1 and in_ready=0.

## Test plan
- Reset then single R word 0x012A4020 (add $t0,$t1,$t2): one cycle later out_valid=1, OpCode=0, Rs=9, Rt=10, Rd=8, funct=0x20, InstType=0, ImmExt=0.
- I words 0x2108FFFF (addi), 0x3108FFFF (andi), 0x3C081234 (lui), XLEN=32: ImmExt=0xFFFFFFFF, 0x0000FFFF, 0x12340000 respectively; InstType=1; Rd=0.
- J word 0x0C000010 (jal) with PC=0x8000_0FFC: target=0x10, JumpAddr=0x8000_0040, InstType=2, Rs=Rt=0.
- Backpressure, DEPTH=2: push 3 words with out_ready=0. Third push sees in_ready=0; after 2 pushes outputs hold word 1. Raise out_ready: words emerge in order 1, 2, then the third is accepted the cycle after the first pop.
- Streaming, out_ready=1, 100 random words: one output per cycle, exact order, and ImmExt/JumpAddr match the reference model across pointer wrap-around.
- Flush asserted with 2 entries buffered and in_valid=1: next cycle out_valid=0, in_ready=1, flushed input absent. Repeat with rst_n=0 mid-stream: same empty state.
